dat_mem_arb: RTL and testbench

Two-port round-robin arbiter and sequencer that shares the single-port 8-bit data memory between two requesters: port 0 is the core load/store unit and port 1 is the loader/debug engine. It drives the memory's address, write-data and write-enable pins. It registers read data toward the winning requester and flags out-of-range addresses. Bounded burst locking lets one requester do multi-byte accesses without interleaving, without starving the other port.

---
 rtl/dat_mem_arb.sv | 160 ++++++++++++++++
 tb/tb_dat_mem_arb.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dat_mem_arb.sv
// Round-robin arbiter sharing one single-port data memory between the load/store
// unit (port 0) and the loader/debug engine (port 1), with bounded burst locking.
module dat_mem_arb #(
  parameter int unsigned DW        = 8,
  parameter int unsigned AW        = 8,
  parameter int unsigned DEPTH     = 120,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic          lock0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic          err0,
  input  logic          req1,
  input  logic          we1,
  input  logic          lock1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic          err1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wr_en,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] MAX_B   = BW'(MAX_BURST);
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  owner_e        owner_q, owner_d, win_owner;
  logic [BW-1:0] burst_q, burst_d;
  logic          last_q, last_d;
  logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic          err0_q, err0_d, err1_q, err1_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          hold0, hold1, any_gnt, sel_we, sel_lock, in_range, needs_resp;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // State register; reset also discards any response still in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q   <= OWN_NONE;
      burst_q   <= '0;
      last_q    <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      owner_q   <= owner_d;
      burst_q   <= burst_d;
      last_q    <= last_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      rdata_q   <= rdata_d;
    end
  end

  // Grant selection, memory drive and next-state; grants are held low during reset.
  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    sel_addr   = '0;
    sel_wdata  = '0;
    sel_we     = 1'b0;
    sel_lock   = 1'b0;
    in_range   = 1'b0;
    needs_resp = 1'b0;
    win_owner  = OWN_NONE;
    owner_d    = owner_q;
    burst_d    = burst_q;
    last_d     = last_q;
    rvalid0_d  = 1'b0;
    rvalid1_d  = 1'b0;
    err0_d     = 1'b0;
    err1_d     = 1'b0;
    rdata_d    = rdata_q;

    hold0 = (owner_q == OWN_P0) && req0 && (!req1 || (burst_q < MAX_B));
    hold1 = (owner_q == OWN_P1) && req1 && (!req0 || (burst_q < MAX_B));

    if (!reset) begin
      if (hold0)              gnt0 = 1'b1;
      else if (hold1)         gnt1 = 1'b1;
      else if (req0 && !req1) gnt0 = 1'b1;
      else if (req1 && !req0) gnt1 = 1'b1;
      else if (req0 && req1) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end
    end
    any_gnt = gnt0 | gnt1;

    if (gnt0) begin
      sel_addr  = addr0;
      sel_wdata = wdata0;
      sel_we    = we0;
      sel_lock  = lock0;
      win_owner = OWN_P0;
    end else if (gnt1) begin
      sel_addr  = addr1;
      sel_wdata = wdata1;
      sel_we    = we1;
      sel_lock  = lock1;
      win_owner = OWN_P1;
    end
    in_range   = sel_addr < DEPTH_A;
    needs_resp = !sel_we || !in_range;

    if (any_gnt) begin
      last_d = gnt1;
      // Burst count saturates so a lone locked requester cannot wrap it.
      if (sel_lock) begin
        owner_d = win_owner;
        if (owner_q == win_owner) burst_d = (burst_q == MAX_B) ? burst_q : burst_q + BW'(1);
        else                      burst_d = BW'(1);
      end else begin
        owner_d = OWN_NONE;
        burst_d = '0;
      end
      rvalid0_d = gnt0 && needs_resp;
      rvalid1_d = gnt1 && needs_resp;
      err0_d    = gnt0 && !in_range;
      err1_d    = gnt1 && !in_range;
      if (!sel_we) rdata_d = in_range ? mem_rdata : '0;
    end else begin
      owner_d = OWN_NONE;
      burst_d = '0;
    end
  end

  assign mem_addr  = sel_addr;
  assign mem_wdata = sel_wdata;
  assign mem_wr_en = any_gnt && sel_we && in_range;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign err0      = err0_q;
  assign err1      = err1_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_dat_mem_arb.sv
// Randomized bench for dat_mem_arb against a port-indexed arbitration and memory model.
module tb_dat_mem_arb;

  localparam int DEPTH = 120;
  localparam int MAXB  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, we0, lock0, req1, we1, lock1;
  logic [7:0] addr0, wdata0, addr1, wdata1;
  logic       gnt0, rvalid0, err0, gnt1, rvalid1, err1;
  logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic       mem_wr_en;

  logic [7:0] dut_mem [0:127];
  logic [7:0] ref_mem [0:127];

  int         n_checks = 0;
  int         n_errors = 0;
  int         m_last, m_owner, m_burst;
  logic [7:0] m_rdata;

  always #5 clk = ~clk;

  dat_mem_arb dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .err0(err0),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .err1(err1),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wr_en(mem_wr_en), .mem_rdata(mem_rdata)
  );

  // Behavioural single-port memory seen by the DUT.
  assign mem_rdata = (int'(mem_addr) < DEPTH) ? dut_mem[mem_addr[6:0]] : 8'h00;
  always @(posedge clk) if (mem_wr_en) dut_mem[mem_addr[6:0]] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last  = 1;
    m_owner = -1;
    m_burst = 0;
    m_rdata = 8'h00;
  endtask

  // One arbitration cycle: drive, check grant/memory pins, advance model, check responses.
  task automatic step(input bit r0, input bit w0, input bit l0, input logic [7:0] a0, input logic [7:0] d0,
                      input bit r1, input bit w1, input bit l1, input logic [7:0] a1, input logic [7:0] d1);
    bit         rq[2], wr[2], lk[2], rv[2], er[2];
    logic [7:0] ad[2], wd[2];
    int         g, gi;
    bit         ok;
    rq[0] = r0; wr[0] = w0; lk[0] = l0; ad[0] = a0; wd[0] = d0;
    rq[1] = r1; wr[1] = w1; lk[1] = l1; ad[1] = a1; wd[1] = d1;
    req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
    #2;
    g = -1;
    for (int p = 0; p < 2; p++)
      if (m_owner == p && rq[p] && (!rq[1-p] || m_burst < MAXB)) g = p;
    if (g < 0) begin
      if (rq[0] && !rq[1])      g = 0;
      else if (rq[1] && !rq[0]) g = 1;
      else if (rq[0] && rq[1])  g = 1 - m_last;
    end
    gi = (g < 0) ? 0 : g;
    ok = (g >= 0) && (int'(ad[gi]) < DEPTH);
    check("gnt0", 32'(gnt0), 32'(g == 0));
    check("gnt1", 32'(gnt1), 32'(g == 1));
    check("mem_wr_en", 32'(mem_wr_en), 32'(g >= 0 && wr[gi] && ok));
    check("mem_addr", 32'(mem_addr), (g >= 0) ? 32'(ad[gi]) : 32'd0);
    check("mem_wdata", 32'(mem_wdata), (g >= 0) ? 32'(wd[gi]) : 32'd0);
    rv[0] = 0; rv[1] = 0; er[0] = 0; er[1] = 0;
    if (g >= 0) begin
      if (wr[g] && ok) ref_mem[ad[g][6:0]] = wd[g];
      if (!wr[g]) m_rdata = ok ? ref_mem[ad[g][6:0]] : 8'h00;
      rv[g] = !wr[g] || !ok;
      er[g] = !ok;
      if (lk[g]) begin
        m_burst = (m_owner == g) ? ((m_burst + 1 > MAXB) ? MAXB : m_burst + 1) : 1;
        m_owner = g;
      end else begin
        m_owner = -1;
        m_burst = 0;
      end
      m_last = g;
    end else begin
      m_owner = -1;
      m_burst = 0;
    end
    @(posedge clk);
    #1;
    check("rvalid0", 32'(rvalid0), 32'(rv[0]));
    check("rvalid1", 32'(rvalid1), 32'(rv[1]));
    check("err0", 32'(err0), 32'(er[0]));
    check("err1", 32'(err1), 32'(er[1]));
    check("rdata", 32'(rdata), 32'(m_rdata));
  endtask

  function automatic logic [7:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 6)       return 8'($urandom_range(0, DEPTH - 1));
    else if (sel == 6) return 8'(DEPTH - 1);
    else if (sel == 7) return 8'(DEPTH);
    else               return 8'($urandom_range(DEPTH, 255));
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, {30'd0, gnt1, gnt0}, 32'd0);
    check({tag, "_rv"}, {28'd0, rvalid1, rvalid0, err1, err0}, 32'd0);
    check({tag, "_mem"}, {mem_wr_en, 7'd0, mem_addr, 8'd0, mem_wdata}, 32'd0);
    check({tag, "_rdata"}, 32'(rdata), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      dut_mem[i] = 8'($urandom);
      ref_mem[i] = dut_mem[i];
    end
    model_reset();
    reset = 1'b1;
    req0 = 1; we0 = 1; lock0 = 1; addr0 = 8'd3; wdata0 = 8'h55;
    req1 = 1; we1 = 0; lock1 = 0; addr1 = 8'd4; wdata1 = 8'h66;
    #12;
    check_all_zero("reset");
    req0 = 0; req1 = 0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Write then read back on port 0.
    step(1, 1, 0, 8'd10, 8'hA5, 0, 0, 0, 8'd0, 8'd0);
    step(1, 0, 0, 8'd10, 8'h00, 0, 0, 0, 8'd0, 8'd0);
    check("readback_a5", 32'(rdata), 32'hA5);
    step(0, 0, 0, 8'd0, 8'd0, 0, 0, 0, 8'd0, 8'd0);

    // Both read, no lock: alternation.
    for (int i = 0; i < 6; i++)
      step(1, 0, 0, 8'(i), 8'd0, 1, 0, 0, 8'(i + 50), 8'd0);

    // Port 1 locked burst against continuous port 0.
    for (int i = 0; i < 10; i++)
      step(1, 0, 0, 8'd20, 8'd0, 1, 0, 1, 8'(30 + i), 8'd0);

    // Out-of-range write and read, then top valid address.
    step(1, 1, 0, 8'd120, 8'h3C, 0, 0, 0, 8'd0, 8'd0);
    step(1, 0, 0, 8'd200, 8'h00, 0, 0, 0, 8'd0, 8'd0);
    step(1, 1, 0, 8'd119, 8'h77, 0, 0, 0, 8'd0, 8'd0);
    step(1, 0, 0, 8'd119, 8'h00, 0, 0, 0, 8'd0, 8'd0);
    check("addr119_data", 32'(rdata), 32'h77);

    // Lock owner port 0 drops its request while port 1 waits.
    step(1, 0, 1, 8'd5, 8'd0, 1, 0, 0, 8'd6, 8'd0);
    step(1, 0, 1, 8'd5, 8'd0, 1, 0, 0, 8'd6, 8'd0);
    step(0, 0, 0, 8'd5, 8'd0, 1, 0, 0, 8'd6, 8'd0);

    // Asynchronous reset in the middle of a port 0 burst.
    step(0, 0, 0, 8'd0, 8'd0, 0, 0, 0, 8'd0, 8'd0);
    step(1, 0, 1, 8'd7, 8'd0, 0, 0, 0, 8'd0, 8'd0);
    step(1, 0, 1, 8'd8, 8'd0, 0, 0, 0, 8'd0, 8'd0);
    check("burst_is_2", 32'(m_burst), 32'd2);
    req0 = 1; we0 = 1; lock0 = 1; addr0 = 8'd9; wdata0 = 8'hEE;
    req1 = 1; we1 = 0; addr1 = 8'd11;
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    #3;
    check_all_zero("held_reset");
    reset = 1'b0;
    model_reset();
    step(1, 0, 0, 8'd12, 8'd0, 1, 0, 0, 8'd13, 8'd0);
    check("tie_after_reset_rv0", 32'(rvalid0), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1,
           rand_addr(), 8'($urandom),
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1,
           rand_addr(), 8'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
